// File: rtl/lms_pkg.sv
// lms_pkg: Q-format widths, adaptation FSM states and the 16-bit saturator shared by the LMS block.
package lms_pkg;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;
    localparam int FRAC_W   = 15;

    typedef enum logic [2:0] {IDLE, ERR, FETCH, UPDATE, DONE} state_t;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        return (v > 32'sd32767) ? 16'sh7fff : (v < -32'sd32768) ? 16'sh8000 : v[SAMPLE_W-1:0];
    endfunction
endpackage

// File: rtl/lms_saturate.sv
// lms_saturate: signed saturating narrower from IN_W to OUT_W bits (IN_W > OUT_W).
module lms_saturate #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [OUT_W-1:0] MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W-OUT_W:0] top;

    // in range exactly when every bit above the output sign bit repeats it
    assign top  = din[IN_W-1:OUT_W-1];
    assign dout = (&top || ~|top) ? din[OUT_W-1:0] : (din[IN_W-1] ? MIN : MAX);
endmodule

// File: rtl/lms_weight_update.sv
// lms_weight_update: LMS error and per-tap weight adaptation with a combinational weight read port.
// Define LMS_LEAKAGE_EN to build the leaky-LMS weight update.
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int TAPS       = 8,
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ACC_W-1:0]         y_in,
    input  logic [SAMPLE_W-1:0]      d_in,
    input  logic                     y_valid,
    input  logic                     adapt_en,
    output logic [$clog2(TAPS)-1:0]  x_addr,
    input  logic [SAMPLE_W-1:0]      x_data,
    input  logic [$clog2(TAPS)-1:0]  w_rd_addr,
    output logic [SAMPLE_W-1:0]      w_rd_data,
    output logic [SAMPLE_W-1:0]      err_out,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    if (TAPS < 2 || TAPS > 64 || LEAK_SHIFT < 0 || LEAK_SHIFT > 16) begin : g_param_check
        $error("lms_weight_update: TAPS or LEAK_SHIFT out of range");
    end

    state_t state, state_n;
    logic signed [ACC_W-1:0]    y_r, y_sh, p;
    logic signed [SAMPLE_W-1:0] d_r, y16, e_sat, w_cur, w_new;
    logic signed [SAMPLE_W:0]   e_wide, delta, w_ext, w_sum;
    logic signed [SAMPLE_W-1:0] w [TAPS];
    logic                       adapt_r;

    assign y_sh   = y_r >>> FRAC_W;
    assign e_wide = {d_r[SAMPLE_W-1], d_r} - {y16[SAMPLE_W-1], y16};
    assign p      = $signed(err_out) * $signed(x_data);
    assign delta  = (SAMPLE_W+1)'(p >>> (FRAC_W + MU_SHIFT));
    assign w_cur  = w[x_addr];
    assign w_ext  = {w_cur[SAMPLE_W-1], w_cur};
`ifdef LMS_LEAKAGE_EN
    assign w_sum  = w_ext - (w_ext >>> LEAK_SHIFT) + delta;
`else
    assign w_sum  = w_ext + delta;
`endif

    lms_saturate #(.IN_W(ACC_W),      .OUT_W(SAMPLE_W)) u_sat_y (.din(y_sh),   .dout(y16));
    lms_saturate #(.IN_W(SAMPLE_W+1), .OUT_W(SAMPLE_W)) u_sat_e (.din(e_wide), .dout(e_sat));
    lms_saturate #(.IN_W(SAMPLE_W+1), .OUT_W(SAMPLE_W)) u_sat_w (.din(w_sum),  .dout(w_new));

    assign w_rd_data = w[w_rd_addr];
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = y_valid ? ERR : IDLE;
            ERR:     state_n = adapt_r ? FETCH : DONE;
            FETCH:   state_n = UPDATE;
            UPDATE:  state_n = (x_addr == LAST) ? DONE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    // x_addr doubles as the tap index and only moves on entry to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            err_out <= '0;
            x_addr  <= '0;
            y_r     <= '0;
            d_r     <= '0;
            adapt_r <= 1'b0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && y_valid) begin
                y_r     <= y_in;
                d_r     <= d_in;
                adapt_r <= adapt_en;
            end
            if (state == ERR) begin
                err_out <= e_sat;
                if (adapt_r) x_addr <= '0;
            end
            if (state == UPDATE) begin
                w[x_addr] <= w_new;
                if (x_addr != LAST) x_addr <= x_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lms_weight_update.sv
// tb_lms_weight_update: scoreboard bench for lms_weight_update; instance a uses MU_SHIFT=4, instance b MU_SHIFT=0.
module tb_lms_weight_update;
    localparam int TAPS = 4;

    typedef struct {
        logic [15:0]           err;
        logic [TAPS-1:0][15:0] w;
        int                    lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_y, b_y;
    logic [15:0] a_d, b_d, a_xdata, b_xdata, a_wdata, b_wdata, a_err, b_err;
    logic        a_valid, b_valid, a_adapt, b_adapt, a_busy, b_busy, a_done, b_done;
    logic [1:0]  a_xaddr, b_xaddr, a_waddr, b_waddr;

    logic signed [15:0] xmem [TAPS];
    int wm_a [TAPS];
    int wm_b [TAPS];
    exp_t sbq [$];
    int n_checks = 0;
    int n_fail = 0;
    int a_done_cnt = 0;

    lms_weight_update #(.TAPS(TAPS), .MU_SHIFT(4)) dut_a (
        .clk(clk), .reset(reset), .y_in(a_y), .d_in(a_d), .y_valid(a_valid), .adapt_en(a_adapt),
        .x_addr(a_xaddr), .x_data(a_xdata), .w_rd_addr(a_waddr), .w_rd_data(a_wdata),
        .err_out(a_err), .busy(a_busy), .done(a_done)
    );

    lms_weight_update #(.TAPS(TAPS), .MU_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .y_in(b_y), .d_in(b_d), .y_valid(b_valid), .adapt_en(b_adapt),
        .x_addr(b_xaddr), .x_data(b_xdata), .w_rd_addr(b_waddr), .w_rd_data(b_wdata),
        .err_out(b_err), .busy(b_busy), .done(b_done)
    );

    // tap delay line model: registered read, data one cycle after address
    always @(posedge clk) begin
        a_xdata <= xmem[a_xaddr];
        b_xdata <= xmem[b_xaddr];
    end

    always @(negedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint floor_div(input longint v, input int sh);
        longint den, q;
        den = longint'(1) << sh;
        q = v / den;
        if ((v % den) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    task automatic push_exp(input bit sel_b, input logic [31:0] y, input logic [15:0] d, input bit adapt);
        exp_t ex;
        int y16, e, wk, nw, mu;
        longint leak;
        mu = sel_b ? 0 : 4;
        y16 = sat(floor_div(longint'($signed(y)), 15));
        e = sat(longint'($signed(d)) - y16);
        for (int k = 0; k < TAPS; k++) begin
            wk = sel_b ? wm_b[k] : wm_a[k];
            nw = wk;
            if (adapt) begin
                leak = 0;
`ifdef LMS_LEAKAGE_EN
                leak = floor_div(longint'(wk), 8);
`endif
                nw = sat(longint'(wk) - leak + floor_div(longint'(e) * xmem[k], 15 + mu));
            end
            if (sel_b) wm_b[k] = nw; else wm_a[k] = nw;
            ex.w[k] = 16'(nw);
        end
        ex.err = 16'(e);
        ex.lat = adapt ? 2 + 2 * TAPS : 2;
        sbq.push_back(ex);
    endtask

    task automatic drive(input bit sel_b, input bit v, input logic [31:0] y, input logic [15:0] d, input bit ad);
        if (sel_b) begin
            b_valid = v; b_y = y; b_d = d; b_adapt = ad;
        end else begin
            a_valid = v; a_y = y; a_d = d; a_adapt = ad;
        end
    endtask

    task automatic run_update(input bit sel_b, input logic [31:0] y, input logic [15:0] d, input bit adapt, input int inj_at);
        exp_t ex;
        int n;
        push_exp(sel_b, y, d, adapt);
        @(posedge clk); #1;
        drive(sel_b, 1'b1, y, d, adapt);
        @(posedge clk); #1;
        drive(sel_b, 1'b0, y, d, adapt);
        n = 1;
        n_checks++;
        if ((sel_b ? b_busy : a_busy) !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: got %b want 1", sel_b ? b_busy : a_busy);
        end
        while ((sel_b ? b_done : a_done) !== 1'b1 && n < 40) begin
            drive(sel_b, n == inj_at, 32'h7fff_0000, 16'h8000, 1'b1);
            @(posedge clk); #1;
            n++;
        end
        drive(sel_b, 1'b0, y, d, adapt);
        ex = sbq.pop_front();
        n_checks++;
        if (n !== ex.lat) begin
            n_fail++;
            $display("FAIL done_latency: got %0d want %0d", n, ex.lat);
        end
        n_checks++;
        if ((sel_b ? b_err : a_err) !== ex.err) begin
            n_fail++;
            $display("FAIL err_out: got %h want %h", sel_b ? b_err : a_err, ex.err);
        end
        @(posedge clk); #1;
        n_checks++;
        if ((sel_b ? {b_done, b_busy} : {a_done, a_busy}) !== 2'b00) begin
            n_fail++;
            $display("FAIL done_single: got done/busy %b want 00", sel_b ? {b_done, b_busy} : {a_done, a_busy});
        end
        for (int k = 0; k < TAPS; k++) begin
            if (sel_b) b_waddr = 2'(k); else a_waddr = 2'(k);
            #1;
            n_checks++;
            if ((sel_b ? b_wdata : a_wdata) !== ex.w[k]) begin
                n_fail++;
                $display("FAIL weight[%0d]: got %h want %h", k, sel_b ? b_wdata : a_wdata, ex.w[k]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_err, b_err} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_err: got %h/%h want 0", a_err, b_err);
        end
        n_checks++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {a_busy, a_done, b_busy, b_done});
        end
        for (int k = 0; k < TAPS; k++) begin
            a_waddr = 2'(k);
            b_waddr = 2'(k);
            #1;
            n_checks++;
            if ({a_wdata, b_wdata} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_weight[%0d]: got %h/%h want 0", k, a_wdata, b_wdata);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'sh4000;
        run_update(1'b0, 32'h0, 16'h4000, 1'b1, 0);
    endtask

    task automatic test_err_sat;
        run_update(1'b0, 32'h8000_0000, 16'h7fff, 1'b0, 0);
    endtask

    task automatic test_weight_sat;
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'sh7fff;
        run_update(1'b1, 32'h0, 16'h7fff, 1'b1, 0);
        run_update(1'b1, 32'h0, 16'h7fff, 1'b1, 0);
    endtask

    task automatic test_no_adapt;
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'sh4000;
        run_update(1'b0, 32'h0, 16'h4000, 1'b0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < TAPS; k++) xmem[k] = 16'($urandom);
            run_update(1'b0, $urandom, 16'($urandom), 1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = a_done_cnt;
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'sh2000 + 16'(k * 16'h0400);
        run_update(1'b0, 32'h1000_0000, 16'h0100, 1'b1, 3);
        n_checks++;
        if (a_done_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL ignored_valid: got %0d done pulses want 1", a_done_cnt - c0);
        end
    endtask

    task automatic test_reset_abort;
        int c0;
        c0 = a_done_cnt;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0, 16'h4000, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 16'h4000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b want 0", a_busy);
        end
        reset = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            wm_a[k] = 0;
            wm_b[k] = 0;
            a_waddr = 2'(k);
            #1;
            n_checks++;
            if (a_wdata !== 16'h0) begin
                n_fail++;
                $display("FAIL abort_weight[%0d]: got %h want 0", k, a_wdata);
            end
        end
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (a_done_cnt !== c0) begin
            n_fail++;
            $display("FAIL abort_done: got %0d done pulses want 0", a_done_cnt - c0);
        end
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'($urandom);
        run_update(1'b0, 32'hffff_8000, 16'hc000, 1'b1, 0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        a_waddr = '0;
        b_waddr = '0;
        for (int k = 0; k < TAPS; k++) begin
            xmem[k] = '0;
            wm_a[k] = 0;
            wm_b[k] = 0;
        end
        test_reset;
        test_basic;
        test_err_sat;
        test_weight_sat;
        test_no_adapt;
        test_random;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lms_weight_update.md
Name: lms_weight_update

Overview:
- Adaptation stage directly downstream of the MAC filter.
- Consumes the accumulated filter output y and the desired sample d, forms the error e = d - y, then walks all taps applying w[k] += mu*e*x[k].
- Owns the weight register file and serves weights back to the MAC sequencer through a read port.
- Reads sample history from the external tap delay line.

Parameters:
- TAPS, 8, number of filter taps (2..64).
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT.
- LEAK_SHIFT, 8, leakage factor 2^-LEAK_SHIFT; used only with LMS_LEAKAGE_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- y_in  in  32  MAC output, signed Q2.30.
- d_in  in  16  desired sample, signed Q1.15.
- y_valid  in  1  y_in/d_in valid, single-cycle pulse.
- adapt_en  in  1  high: update weights; low: error only. Sampled with y_valid.
- x_addr  out  $clog2(TAPS)  sample-history read address.
- x_data  in  16  sample at x_addr, signed Q1.15, valid one cycle after address.
- w_rd_addr  in  $clog2(TAPS)  weight read address for the MAC sequencer.
- w_rd_data  out  16  weight[w_rd_addr], combinational, signed Q1.15.
- err_out  out  16  last error, signed Q1.15.
- busy  out  1  update in progress.
- done  out  1  one-cycle pulse at the end of an update.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over everything.
- Reset values: all weights 0, err_out 0, busy 0, done 0, x_addr 0, state IDLE.
- FSM states: IDLE, ERR, FETCH, UPDATE, DONE.
- IDLE:
  - y_valid at cycle T captures y_in, d_in and adapt_en; state goes to ERR.
  - busy rises at T+1.
- ERR (T+1):
  - y16 = sat16(y_in >>> 15).
  - e = sat16(d_in - y16), computed at 17 bits.
  - err_out is registered at the end of this cycle.
  - If adapt_en was low, go to DONE. Otherwise k = 0, go to FETCH.
- FETCH: drive x_addr = k; go to UPDATE.
- UPDATE: compute the new weight and write it back.
  - p = e * x_data, 32-bit signed.
  - delta = p >>> (15 + MU_SHIFT). Arithmetic shift, floor, no rounding.
  - w[k] <= sat16(w[k] + delta), computed at 17 bits.
  - If k == TAPS-1, go to DONE. Otherwise k++ and go to FETCH.
  - Two cycles per tap.
- DONE: done = 1 for exactly one cycle; busy = 1 in this cycle; next state IDLE.
- Latency: done asserts at T+2+2*TAPS when adapting, and at T+2 when adapt_en = 0.
- y_valid while not in IDLE (including the DONE cycle) is ignored. No queuing.
- sat16 clamps to the range 0x8000..0x7FFF.
- w_rd_data always reflects current register contents. During busy it may mix old and new weights. The MAC sequencer must not start a filter pass while busy = 1.
- Reset mid-update aborts immediately, clears all weights, and produces no done pulse.
- x_addr holds its last value outside FETCH.

Optional Feature:
- LMS_LEAKAGE_EN defined: leaky LMS. w[k] <= sat16(w[k] - (w[k] >>> LEAK_SHIFT) + delta); the leak term is computed from the pre-update weight.
- Not defined: standard LMS as above; LEAK_SHIFT is unused.
- The leak applies only in UPDATE; the adapt_en = 0 path is unchanged.

Decomposition:
- Package lms_pkg holds:
  - Q-format width constants (SAMPLE_W = 16, ACC_W = 32, FRAC_W = 15).
  - the FSM state enum typedef.
  - the sat16 function.
- One sub-module: lms_saturate, a parameterised signed saturating narrower (IN_W to OUT_W). It is instantiated for the y16, e and weight-write paths.

Test Plan (TAPS = 4 unless stated):
1. Reset: assert reset for 2 cycles -> w_rd_data = 0 for all addresses; err_out = 0, busy = 0, done = 0.
2. Basic update, MU_SHIFT = 4: y_in = 0, d_in = 0x4000, all x = 0x4000, adapt_en = 1, y_valid at T -> err_out = 0x4000; every weight = 0x0200; done only at T+10.
3. Error saturation: y_in = 32'h8000_0000, d_in = 0x7FFF -> y16 = 0x8000; err_out = 0x7FFF, not wrapped.
4. Weight saturation, MU_SHIFT = 0: y_in = 0, d_in = 0x7FFF, all x = 0x7FFF; run two updates -> weights 0x7FFE after the first, 0x7FFF after the second.
5. adapt_en = 0 with the same stimulus as scenario 2 -> err_out = 0x4000; weights unchanged; done at T+2.
6. Protocol: pulse y_valid at T+3 during an update -> ignored, single done. Assert reset at T+5 -> busy = 0 next cycle, weights 0, no done pulse.
